// File: rtl/ledm_pkg.sv
// ledm_pkg: shared scan states, brightness constants and a clog2 helper
// for the LED-matrix scan driver.
package ledm_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  localparam int BRIGHT_W  = 4;
  localparam int PWM_SLOTS = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ledm_fbuf.sv
// ledm_fbuf: two-bank frame buffer. Writes target the back bank (!disp);
// the display bank is read combinationally at rd_col. Reset clears both banks.
module ledm_fbuf
  import ledm_pkg::*;
#(
  parameter int N_COLS = 5,
  parameter int N_ROWS = 8,
  parameter int CW     = clog2(N_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_col,
  input  logic [N_ROWS-1:0] wr_data,
  input  logic              disp,
  input  logic [CW-1:0]     rd_col,
  output logic [N_ROWS-1:0] rd_data
);

  localparam logic [CW:0] N_COLS_W = (CW+1)'(N_COLS);

  logic [N_ROWS-1:0] mem_q [2][N_COLS];
  logic [N_ROWS-1:0] mem_d [2][N_COLS];

  // Back-bank write; out-of-range columns are dropped.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && ({1'b0, wr_col} < N_COLS_W)) begin
      mem_d[~disp][wr_col] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage with asynchronous clear of both banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < N_COLS; c++) begin
          mem_q[b][c] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[disp][rd_col];

endmodule

// File: rtl/ledm_scan_driver.sv
// ledm_scan_driver: double-buffered column-multiplexed LED-matrix scanner.
// Define LEDM_PWM_EN to add the 16-slot per-dwell brightness control (bright port).
module ledm_scan_driver
  import ledm_pkg::*;
#(
  parameter int N_COLS         = 5,
  parameter int N_ROWS         = 8,
  parameter int DWELL_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 50,
  parameter int COL_ACTIVE_LOW = 1,
  parameter int ROW_ACTIVE_LOW = 0
) (
  input  logic                     CLOCK_50MHz,
  input  logic                     RESET,
  input  logic                     wr_en,
  input  logic [clog2(N_COLS)-1:0] wr_col,
  input  logic [N_ROWS-1:0]        wr_data,
  input  logic                     swap_req,
`ifdef LEDM_PWM_EN
  input  logic [BRIGHT_W-1:0]      bright,
`endif
  output logic                     swap_done,
  output logic                     frame_start,
  output logic [N_COLS-1:0]        LEDM_C,
  output logic [N_ROWS-1:0]        LEDM_R
);

  localparam int CW      = clog2(N_COLS);
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]     COL_LAST   = CW'(N_COLS - 1);
  localparam logic              COL_INV    = (COL_ACTIVE_LOW != 0);
  localparam logic              ROW_INV    = (ROW_ACTIVE_LOW != 0);
  localparam logic [N_COLS-1:0] C_OFF      = {N_COLS{COL_INV}};
  localparam logic [N_ROWS-1:0] R_OFF      = {N_ROWS{ROW_INV}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]     col_q, col_d;
  logic              disp_q, disp_d;
  logic              pend_q, pend_d;
  logic              swap_done_q, swap_done_d;
  logic              frame_start_q, frame_start_d;
  logic [N_COLS-1:0] ledm_c_q, ledm_c_d;
  logic [N_ROWS-1:0] ledm_r_q, ledm_r_d;
  logic [N_COLS-1:0] col_oh_s;
  logic [N_ROWS-1:0] rd_data_s;
  logic              pwm_on_s;

  // Outside a frame-end swap, disp/col are stable whenever DRIVE is entered or held,
  // so reading with the current values gives the row pattern for the next cycle.
  ledm_fbuf #(
    .N_COLS (N_COLS),
    .N_ROWS (N_ROWS),
    .CW     (CW)
  ) u_fbuf (
    .clk     (CLOCK_50MHz),
    .rst     (RESET),
    .wr_en   (wr_en),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .disp    (disp_q),
    .rd_col  (col_q),
    .rd_data (rd_data_s)
  );

  // Scan sequencing, swap at frame end and one-cycle pulses.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    col_d         = col_q;
    disp_d        = disp_q;
    pend_d        = pend_q | swap_req;
    swap_done_d   = 1'b0;
    frame_start_d = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d       = ST_DRIVE;
          cnt_d         = '0;
          frame_start_d = (col_q == '0);
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (pend_d) begin
              disp_d      = ~disp_q;
              pend_d      = 1'b0;
              swap_done_d = 1'b1;
            end else begin
              disp_d = disp_q;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        col_d   = '0;
      end
    endcase
  end

`ifdef LEDM_PWM_EN
  localparam int SLOT_LEN = DWELL_CYCLES / PWM_SLOTS;

  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic [CNT_W-1:0]    slot_s;

  // Brightness is latched on DRIVE entry; rows lit while slot index <= brightness.
  always_comb begin
    bright_d = ((state_q == ST_BLANK) && (state_d == ST_DRIVE)) ? bright : bright_q;
    slot_s   = cnt_d / CNT_W'(SLOT_LEN);
    pwm_on_s = (slot_s <= CNT_W'(bright_d));
  end

  // Brightness hold register.
  always_ff @(posedge CLOCK_50MHz or posedge RESET) begin
    if (RESET) begin
      bright_q <= '0;
    end else begin
      bright_q <= bright_d;
    end
  end
`else
  assign pwm_on_s = 1'b1;
`endif

  // Pin values for the next cycle, at the configured polarities.
  always_comb begin
    col_oh_s = N_COLS'(1) << col_d;
    if (state_d == ST_DRIVE) begin
      ledm_c_d = col_oh_s ^ C_OFF;
      ledm_r_d = (pwm_on_s ? rd_data_s : '0) ^ R_OFF;
    end else begin
      ledm_c_d = C_OFF;
      ledm_r_d = R_OFF;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50MHz or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      col_q         <= '0;
      disp_q        <= 1'b0;
      pend_q        <= 1'b0;
      swap_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
      ledm_c_q      <= C_OFF;
      ledm_r_q      <= R_OFF;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      disp_q        <= disp_d;
      pend_q        <= pend_d;
      swap_done_q   <= swap_done_d;
      frame_start_q <= frame_start_d;
      ledm_c_q      <= ledm_c_d;
      ledm_r_q      <= ledm_r_d;
    end
  end

  assign swap_done   = swap_done_q;
  assign frame_start = frame_start_q;
  assign LEDM_C      = ledm_c_q;
  assign LEDM_R      = ledm_r_q;

endmodule

// File: tb/tb_ledm_scan_driver.sv
// Self-checking bench for ledm_scan_driver: a monitor turns pin activity into
// per-column windows which are compared against expected windows queued at stimulus time.
module tb_ledm_scan_driver;

  localparam int NC    = 5;
  localparam int NR    = 8;
  localparam int DWELL = 32;
  localparam int BLANK = 2;

  logic          clk = 1'b0;
  logic          RESET = 1'b1;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_col = 3'd0;
  logic [NR-1:0] wr_data = 8'h00;
  logic          swap_req = 1'b0;
  logic [3:0]    bright = 4'd15;
  logic          swap_done;
  logic          frame_start;
  logic [NC-1:0] LEDM_C;
  logic [NR-1:0] LEDM_R;

  always #5 clk = ~clk;

  ledm_scan_driver #(
    .N_COLS         (NC),
    .N_ROWS         (NR),
    .DWELL_CYCLES   (DWELL),
    .BLANK_CYCLES   (BLANK),
    .COL_ACTIVE_LOW (1),
    .ROW_ACTIVE_LOW (0)
  ) dut (
    .CLOCK_50MHz (clk),
    .RESET       (RESET),
    .wr_en       (wr_en),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
`ifdef LEDM_PWM_EN
    .bright      (bright),
`endif
    .swap_done   (swap_done),
    .frame_start (frame_start),
    .LEDM_C      (LEDM_C),
    .LEDM_R      (LEDM_R)
  );

  typedef struct {
    int         col;
    logic [7:0] rows;
    int         lit;
    int         fs;
  } exp_t;

  typedef struct {
    int         col;
    logic [4:0] c_raw;
    logic [7:0] rows;
    int         blank;
    int         dwell;
    int         lit;
    int         contig;
    int         stable;
    int         fs_first;
    int         fs_cnt;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  int errors = 0;
  int checks = 0;
  int sd_cnt = 0;
  int blank_r_err = 0;

  logic [7:0] m_bank [2][NC];
  bit         m_disp = 1'b0;
  int         m_bright = 15;

  function automatic int dec_col(input logic [4:0] c);
    logic [4:0] oh;
    oh = ~c;
    for (int i = 0; i < NC; i++) begin
      if (oh == (5'b00001 << i)) return i;
    end
    return -1;
  endfunction

  function automatic int exp_lit(input logic [7:0] rows, input int b);
    if (rows == 8'h00) return 0;
`ifdef LEDM_PWM_EN
    return (b + 1) * (DWELL / 16);
`else
    return DWELL;
`endif
  endfunction

  // Window monitor
  initial begin : monitor
    obs_t cur;
    bit   in_drive;
    int   blank_cnt;
    in_drive  = 1'b0;
    blank_cnt = 0;
    cur       = '{default: 0};
    forever begin
      @(negedge clk);
      if (RESET) begin
        in_drive  = 1'b0;
        blank_cnt = 0;
      end else if (LEDM_C === 5'b11111) begin
        if (in_drive) begin
          obs_q.push_back(cur);
          in_drive  = 1'b0;
          blank_cnt = 0;
        end
        blank_cnt++;
        if (LEDM_R !== 8'h00) blank_r_err++;
      end else begin
        if (!in_drive) begin
          in_drive     = 1'b1;
          cur.col      = dec_col(LEDM_C);
          cur.c_raw    = LEDM_C;
          cur.rows     = 8'h00;
          cur.blank    = blank_cnt;
          cur.dwell    = 0;
          cur.lit      = 0;
          cur.contig   = 1;
          cur.stable   = 1;
          cur.fs_first = (frame_start === 1'b1) ? 1 : 0;
          cur.fs_cnt   = 0;
        end
        if (LEDM_C !== cur.c_raw) cur.stable = 0;
        if (LEDM_R !== 8'h00) begin
          if (cur.lit == 0) cur.rows = LEDM_R;
          else if (LEDM_R !== cur.rows) cur.stable = 0;
          if (cur.dwell != cur.lit) cur.contig = 0;
          cur.lit++;
        end
        if (frame_start === 1'b1) cur.fs_cnt++;
        cur.dwell++;
      end
      if (swap_done === 1'b1) sd_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_write(input int col, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_col  = 3'(col);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    if (col < NC) m_bank[!m_disp][col] = data;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic push_window(input int col, input logic [7:0] rows, input int lit);
    exp_t e;
    e.col  = col;
    e.rows = rows;
    e.lit  = lit;
    e.fs   = (col == 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic push_frame();
    for (int c = 0; c < NC; c++) begin
      push_window(c, m_bank[m_disp][c], exp_lit(m_bank[m_disp][c], m_bright));
    end
  endtask

  // Advance to the first blank cycle after column NC-1 and drop older windows.
  task automatic wait_frame_end();
    int n;
    n = 0;
    while (LEDM_C !== 5'b01111 && n < 400) begin tick(); n++; end
    while (LEDM_C === 5'b01111 && n < 400) begin tick(); n++; end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL frame_end_timeout: LEDM_C=%b after %0d cycles, required frame end", LEDM_C, n);
    end
    obs_q.delete();
  endtask

  task automatic check_frames(input int nframes);
    obs_t o;
    exp_t e;
    int   n;
    for (int w = 0; w < nframes * NC; w++) begin
      n = 0;
      while (obs_q.size() == 0 && n < 200) begin tick(); n++; end
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL window_timeout: window %0d not observed (exp queued=%0d)", w, exp_q.size());
        return;
      end
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o.col !== e.col || o.rows !== e.rows || o.blank != BLANK || o.dwell != DWELL ||
          o.lit != e.lit || o.contig != 1 || o.stable != 1 || o.fs_first != e.fs || o.fs_cnt != e.fs) begin
        errors++;
        $display("FAIL window col%0d: got col=%0d rows=%h blank=%0d dwell=%0d lit=%0d contig=%0d stable=%0d fs=%0d/%0d; required col=%0d rows=%h blank=%0d dwell=%0d lit=%0d contig=1 stable=1 fs=%0d/%0d",
                 e.col, o.col, o.rows, o.blank, o.dwell, o.lit, o.contig, o.stable, o.fs_first, o.fs_cnt,
                 e.col, e.rows, BLANK, DWELL, e.lit, e.fs, e.fs);
      end
    end
  endtask

  task automatic wait_col0_after_release(input string name);
    int n;
    n = 0;
    while (LEDM_C !== 5'b11110 && n < 20) begin tick(); n++; end
    checks++;
    if (n != BLANK) begin
      errors++;
      $display("FAIL %s_first_drive: col0 after %0d cycles, required %0d", name, n, BLANK);
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_frame_start: got %b required 1", name, frame_start);
    end
    tick();
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL %s_frame_start_pulse: got %b required 0", name, frame_start);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    checks++;
    if (LEDM_C !== 5'b11111) begin errors++; $display("FAIL reset_cols: got %b required 11111", LEDM_C); end
    checks++;
    if (LEDM_R !== 8'h00) begin errors++; $display("FAIL reset_rows: got %h required 00", LEDM_R); end
    checks++;
    if (swap_done !== 1'b0) begin errors++; $display("FAIL reset_swap_done: got %b required 0", swap_done); end
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b required 0", frame_start); end
    RESET = 1'b0;
    wait_col0_after_release("reset");
    wait_frame_end();
    push_frame();
    check_frames(1);
  endtask

  task automatic test_swap();
    do_write(2, 8'hA5);
    pulse_swap();
    sd_cnt = 0;
    wait_frame_end();
    checks++;
    if (sd_cnt != 1) begin errors++; $display("FAIL swap_done_pulse: got %0d pulses required 1", sd_cnt); end
    m_disp = !m_disp;
    push_frame();
    check_frames(1);
    checks++;
    if (sd_cnt != 1) begin errors++; $display("FAIL swap_done_extra: got %0d pulses required 1", sd_cnt); end
  endtask

  task automatic test_no_swap();
    do_write(1, 8'hFF);
    sd_cnt = 0;
    wait_frame_end();
    for (int f = 0; f < 3; f++) push_frame();
    check_frames(3);
    checks++;
    if (sd_cnt != 0) begin errors++; $display("FAIL no_swap_done: got %0d pulses required 0", sd_cnt); end
  endtask

  task automatic test_boundary();
    int n;
    n = 0;
    while (LEDM_C !== 5'b01111 && n < 400) begin tick(); n++; end
    repeat (DWELL - 1) tick();
    wr_en    = 1'b1;
    wr_col   = 3'd0;
    wr_data  = 8'h3C;
    swap_req = 1'b1;
    tick();
    wr_en    = 1'b0;
    swap_req = 1'b0;
    checks++;
    if (swap_done !== 1'b1 || LEDM_C !== 5'b11111) begin
      errors++;
      $display("FAIL boundary_swap: swap_done=%b LEDM_C=%b required 1 and 11111", swap_done, LEDM_C);
    end
    m_bank[!m_disp][0] = 8'h3C;
    m_disp = !m_disp;
    obs_q.delete();
    push_frame();
    check_frames(1);
    // Out-of-range column alongside a valid one
    do_write(3, 8'h5A);
    do_write(6, 8'h77);
    pulse_swap();
    wait_frame_end();
    m_disp = !m_disp;
    push_frame();
    check_frames(1);
  endtask

  task automatic test_midscan_reset();
    int n;
    n = 0;
    while (LEDM_C !== 5'b10111 && n < 400) begin tick(); n++; end
    repeat (10) tick();
    checks++;
    if (LEDM_R !== m_bank[m_disp][3]) begin
      errors++;
      $display("FAIL midscan_rows_before: got %h required %h", LEDM_R, m_bank[m_disp][3]);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (LEDM_C !== 5'b11111 || LEDM_R !== 8'h00 || swap_done !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL midscan_async: C=%b R=%h sd=%b fs=%b required 11111 00 0 0", LEDM_C, LEDM_R, swap_done, frame_start);
    end
    repeat (2) tick();
    RESET = 1'b0;
    for (int b = 0; b < 2; b++) for (int c = 0; c < NC; c++) m_bank[b][c] = 8'h00;
    m_disp = 1'b0;
    wait_col0_after_release("midscan");
    wait_frame_end();
    push_frame();
    check_frames(1);
    pulse_swap();
    wait_frame_end();
    m_disp = !m_disp;
    push_frame();
    check_frames(1);
  endtask

`ifdef LEDM_PWM_EN
  task automatic test_pwm();
    for (int c = 0; c < NC; c++) do_write(c, 8'h81);
    pulse_swap();
    wait_frame_end();
    m_disp = !m_disp;
    bright = 4'd3;
    push_window(0, 8'h81, exp_lit(8'h81, 3));
    for (int c = 1; c < NC; c++) push_window(c, 8'h81, exp_lit(8'h81, 15));
    repeat (12) tick();
    bright = 4'd15;
    check_frames(1);
    bright   = 4'd3;
    m_bright = 3;
    push_frame();
    check_frames(1);
    bright   = 4'd15;
    m_bright = 15;
  endtask
`endif

  initial begin
    for (int b = 0; b < 2; b++) for (int c = 0; c < NC; c++) m_bank[b][c] = 8'h00;
    test_reset();
    test_swap();
    test_no_swap();
    test_boundary();
    test_midscan_reset();
`ifdef LEDM_PWM_EN
    test_pwm();
`endif
    checks++;
    if (blank_r_err != 0) begin
      errors++;
      $display("FAIL rows_in_blank: %0d blank cycles with rows lit, required 0", blank_r_err);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ledm_scan_driver.md
# ledm_scan_driver

Parametrised, time-multiplexed LED-matrix scan driver for the board's column/row LED matrix (default 5 columns × 8 rows). It holds a double-buffered frame image written by a host (Nios PIO or RTL), scans it column by column with inter-column blanking, and drives the LEDM_C/LEDM_R pins directly. It replaces tying those pins to high-Z at the top level.

## Interface
- N_COLS, 5: number of matrix columns (≥2).
- N_ROWS, 8: number of matrix rows (≥1).
- DWELL_CYCLES, 50000: cycles each column is driven (≥16; multiple of 16 when LEDM_PWM_EN is set).
- BLANK_CYCLES, 50: all-off cycles before each column is driven (≥1).
- COL_ACTIVE_LOW, 1: 1 means a column is on when its pin is 0.
- ROW_ACTIVE_LOW, 0: 1 means a row is lit when its pin is 0.

Ports. CW = clog2(N_COLS).
- CLOCK_50MHz  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for the back buffer.
- wr_col  in  CW  column to write.
- wr_data  in  N_ROWS  row pattern; 1 means LED lit.
- swap_req  in  1  one-cycle request to swap buffers at the next frame end.
- bright  in  4  brightness; only present with LEDM_PWM_EN.
- swap_done  out  1  one-cycle pulse when a swap takes effect.
- frame_start  out  1  one-cycle pulse on entering DRIVE for column 0.
- LEDM_C  out  N_COLS  column drive, polarity per COL_ACTIVE_LOW.
- LEDM_R  out  N_ROWS  row drive, polarity per ROW_ACTIVE_LOW.

## Operation
- **Frame buffer:** two banks of N_COLS × N_ROWS bits. Display bank index `disp` resets to 0. Writes always target bank !disp.
- **Writes:** a write with wr_col ≥ N_COLS is ignored.
- **State machine:** two states, BLANK and DRIVE.
  - BLANK: all columns and rows off for BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: column `col` on, rows = bank[disp][col], for DWELL_CYCLES cycles.
  - On leaving DRIVE: col increments and wraps from N_COLS-1 to 0, and state returns to BLANK.
- **Swap:** swap_req sets a pending flag; repeated requests while pending are idempotent. When DRIVE of column N_COLS-1 ends with the flag set:
  - disp toggles, the flag clears, and swap_done pulses in that same transition cycle.
  - Column 0 of the next frame shows the new bank.
- **Simultaneous events:**
  - A swap_req arriving in the exact cycle of the frame-end transition is honoured at that transition.
  - A write in the transition cycle lands in the pre-toggle back bank, i.e. the newly displayed bank.
- **Reset (including mid-scan):**
  - state = BLANK, col = 0, counters = 0, disp = 0, pending = 0.
  - Both banks are cleared.
  - swap_done = 0, frame_start = 0.
  - All columns off and all rows off, at the configured polarities.

## Timing
- Outputs are registered and change on the same edge as the state change. A column is valid for exactly DWELL_CYCLES cycles and the blank lasts exactly BLANK_CYCLES cycles.
- Frame period = N_COLS × (BLANK_CYCLES + DWELL_CYCLES) cycles.
- After RESET deasserts: BLANK_CYCLES cycles of blank, then column 0 is driven and frame_start pulses on that same edge.
- A write appears on the pins no earlier than the next DRIVE of that column after a swap; it never appears mid-dwell.
- Column pins change only during BLANK, so two columns are never on together.

## Configuration
- **Macro LEDM_PWM_EN defined:**
  - Each DWELL_CYCLES window is split into 16 equal slots, indexed 0–15.
  - Rows are enabled only in slots where the index ≤ bright; otherwise rows are off and the column stays on.
  - bright is sampled on entry to DRIVE and held for that dwell.
  - bright = 15 gives full on; bright = 0 gives 1/16 duty.
- **Macro undefined:** the bright port is absent, and rows are on for the whole dwell.

## Structure
- **Package ledm_pkg:**
  - state typedef (BLANK, DRIVE)
  - BRIGHT_W = 4
  - PWM_SLOTS = 16
  - a clog2 helper function
- **Sub-module ledm_fbuf:** the two-bank frame buffer, with a write port plus an asynchronous read of bank[disp][col]. The reset clear lives inside it.

## Test plan
Bench parameters: N_COLS=5, N_ROWS=8, DWELL_CYCLES=32, BLANK_CYCLES=2, COL_ACTIVE_LOW=1, ROW_ACTIVE_LOW=0.
- **Reset:** assert RESET for 3 cycles → LEDM_C=5'b11111, LEDM_R=8'h00, swap_done=0. Release → first column 0 drive (LEDM_C=5'b11110) exactly 2 cycles later, with frame_start high for 1 cycle.
- **Swap:** write col2=8'hA5, then pulse swap_req → swap_done pulses once at frame end. In the next frame, LEDM_C=5'b11011 with LEDM_R=8'hA5 for exactly 32 cycles, preceded by 2 all-off cycles.
- **No swap:** write col1=8'hFF without swap_req → 3 full frames show LEDM_R=8'h00 in column 1.
- **Boundary:** issue swap_req and a write of col0=8'h3C in the frame-end transition cycle → swap honoured and column 0 shows 8'h3C in the next frame. A write to wr_col=6 changes nothing.
- **Mid-scan reset:** assert RESET mid-dwell of column 3 → all outputs inactive within the same cycle (asynchronous). After release, the scan restarts at column 0 and both banks read 0.
- **PWM (LEDM_PWM_EN):**
  - bright=3 → rows lit during dwell cycles 0–7 and off during cycles 8–31.
  - bright=15 → lit all 32 cycles.
  - Changing bright mid-dwell has no effect until the next dwell.
